// File: rtl/boia_pkg.sv
// Shared constants and types for the float-switch conditioner.
package boia_pkg;

  localparam int FAULT_PLAUS_BIT   = 0;
  localparam int FAULT_TIMEOUT_BIT = 1;

  typedef logic [1:0] boia_fault_t;

  // Defaults sized for a 50 MHz clk_fpga: 1 ms debounce, 10 s fill limit.
  localparam int CLK_FPGA_HZ                 = 50_000_000;
  localparam int DEFAULT_DEBOUNCE_CYCLES     = 50_000;
  localparam int DEFAULT_FILL_TIMEOUT_CYCLES = 500_000_000;

endpackage

// File: rtl/boia_conditioner_debounce_channel.sv
// One float channel: 2-FF synchroniser, mismatch counter and accepted (stable) level.
module debounce_channel
  import boia_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk_fpga,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Any cycle agreeing with the accepted level restarts the count, so only
  // an uninterrupted run of DEBOUNCE_CYCLES mismatches is accepted.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/boia_conditioner.sv
// Float-switch conditioner: debounce, startup qualification and sticky supervision faults.
// Optional fill-timeout supervision is compiled in with `define BOIA_FILL_TIMEOUT_EN.
module boia_conditioner
  import boia_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FILL_TIMEOUT_CYCLES = DEFAULT_FILL_TIMEOUT_CYCLES
) (
  input  logic       clk_fpga,
  input  logic       reset,
  input  logic       i_boia_cheia,
  input  logic       i_boia_vazia,
  input  logic       i_enchendo,
  input  logic       i_clear_fault,
  output logic       o_boia_cheia,
  output logic       o_boia_vazia,
  output logic       o_valid,
  output logic       o_fault,
  output logic [1:0] o_fault_code
);

  localparam int STARTUP_W = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [STARTUP_W-1:0] STARTUP_LAST = STARTUP_W'(DEBOUNCE_CYCLES + 1);

  logic [STARTUP_W-1:0] startup_cnt;
  logic                 timeout_cause;
  boia_fault_t          fault_cause;
  boia_fault_t          fault_code_next;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_cheia (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .raw      (i_boia_cheia),
    .level    (o_boia_cheia)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_vazia (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .raw      (i_boia_vazia),
    .level    (o_boia_vazia)
  );

  // Outputs qualify once a full debounce window (plus sync depth) has elapsed.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      startup_cnt <= '0;
      o_valid     <= 1'b0;
    end else if (!o_valid) begin
      if (startup_cnt == STARTUP_LAST) begin
        o_valid <= 1'b1;
      end else begin
        startup_cnt <= startup_cnt + 1'b1;
      end
    end
  end

`ifdef BOIA_FILL_TIMEOUT_EN
  localparam int TMR_W = $clog2(FILL_TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(FILL_TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_PRE = TMR_W'(FILL_TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] fill_timer;
  logic             fill_active;

  assign fill_active = i_enchendo & ~o_boia_cheia;
  // Cause is raised in the cycle whose edge takes the timer to its limit and
  // remains while the timer sits saturated.
  assign timeout_cause = fill_active & (fill_timer >= TMR_PRE);

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      fill_timer <= '0;
    end else if (!fill_active) begin
      fill_timer <= '0;
    end else if (fill_timer != TMR_MAX) begin
      fill_timer <= fill_timer + 1'b1;
    end
  end
`else
  logic unused_fill_cfg;

  assign timeout_cause   = 1'b0;
  assign unused_fill_cfg = ^{i_enchendo, 32'(FILL_TIMEOUT_CYCLES)};
`endif

  // A present cause always wins over a simultaneous clear request.
  always_comb begin
    fault_cause                    = '0;
    fault_cause[FAULT_PLAUS_BIT]   = o_valid & o_boia_cheia & o_boia_vazia;
    fault_cause[FAULT_TIMEOUT_BIT] = timeout_cause;
    fault_code_next                = fault_cause | (o_fault_code & {2{~i_clear_fault}});
  end

  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      o_fault_code <= '0;
    end else begin
      o_fault_code <= fault_code_next;
    end
  end

  assign o_fault = |o_fault_code;

endmodule

// File: tb/tb_boia_conditioner.sv
// Self-checking bench for boia_conditioner with DEBOUNCE_CYCLES=4, FILL_TIMEOUT_CYCLES=10.
module tb_boia_conditioner;

  localparam int DEB = 4;
  localparam int FT  = 10;
`ifdef BOIA_FILL_TIMEOUT_EN
  localparam logic TO = 1'b1;
`else
  localparam logic TO = 1'b0;
`endif

  logic       clk_fpga = 1'b0;
  logic       reset;
  logic       i_boia_cheia;
  logic       i_boia_vazia;
  logic       i_enchendo;
  logic       i_clear_fault;
  logic       o_boia_cheia;
  logic       o_boia_vazia;
  logic       o_valid;
  logic       o_fault;
  logic [1:0] o_fault_code;

  logic [5:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk_fpga = ~clk_fpga;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  boia_conditioner #(
    .DEBOUNCE_CYCLES     (DEB),
    .FILL_TIMEOUT_CYCLES (FT)
  ) dut (
    .clk_fpga      (clk_fpga),
    .reset         (reset),
    .i_boia_cheia  (i_boia_cheia),
    .i_boia_vazia  (i_boia_vazia),
    .i_enchendo    (i_enchendo),
    .i_clear_fault (i_clear_fault),
    .o_boia_cheia  (o_boia_cheia),
    .o_boia_vazia  (o_boia_vazia),
    .o_valid       (o_valid),
    .o_fault       (o_fault),
    .o_fault_code  (o_fault_code)
  );

  // ---------------- checking ----------------
  // Vector layout: {o_valid, o_boia_cheia, o_boia_vazia, o_fault, o_fault_code[1:0]}
  task automatic check_value(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got valid/cheia/vazia/fault/code=%b, expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk_fpga);
  endtask

  task automatic pulse_clear();
    i_clear_fault = 1'b1;
    wait_cycles(1);
    i_clear_fault = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic expect_out(input logic [5:0] e);
    exp_q.push_back(e);
  endtask

  task automatic sample_out(input string tag);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard queue empty at sample", tag);
    end else begin
      e = exp_q.pop_front();
      check_value(tag, {o_valid, o_boia_cheia, o_boia_vazia, o_fault, o_fault_code}, e);
    end
  endtask

  task automatic run_check(input int n, input logic [5:0] e, input string tag);
    expect_out(e);
    wait_cycles(n);
    sample_out(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset         = 1'b1;
    i_boia_cheia  = 1'b0;
    i_boia_vazia  = 1'b0;
    i_enchendo    = 1'b0;
    i_clear_fault = 1'b0;
    wait_cycles(2);
    run_check(0, 6'b000000, "reset_state");

    // Startup qualification: valid on edge DEB+2 after release
    reset = 1'b0;
    run_check(DEB + 1, 6'b000000, "valid_edge5");
    run_check(1, 6'b100000, "valid_edge6");

    // Debounce latency on full float, both directions
    i_boia_cheia = 1'b1;
    run_check(DEB + 1, 6'b100000, "cheia_edge5");
    run_check(1, 6'b110000, "cheia_edge6");
    i_boia_cheia = 1'b0;
    run_check(DEB + 2, 6'b100000, "cheia_fall");

    // Pulse of DEB-1 cycles is rejected, pulse of DEB cycles is accepted
    i_boia_cheia = 1'b1;
    wait_cycles(DEB - 1);
    i_boia_cheia = 1'b0;
    run_check(3, 6'b100000, "glitch3_rejected");
    wait_cycles(4);
    i_boia_cheia = 1'b1;
    wait_cycles(DEB);
    i_boia_cheia = 1'b0;
    run_check(2, 6'b110000, "pulse4_accepted");
    run_check(DEB + 2, 6'b100000, "pulse4_return");

    // Plausibility fault, blocked clear, successful clear
    i_boia_cheia = 1'b1;
    i_boia_vazia = 1'b1;
    run_check(DEB + 2, 6'b111000, "both_debounced");
    run_check(1, 6'b111101, "plaus_set");
    pulse_clear();
    run_check(0, 6'b111101, "plaus_clear_blocked");
    i_boia_vazia = 1'b0;
    run_check(DEB + 2, 6'b110101, "plaus_sticky");
    pulse_clear();
    run_check(0, 6'b110000, "plaus_cleared");
    i_boia_cheia = 1'b0;
    run_check(DEB + 2, 6'b100000, "floats_low");

    // Fill timeout at exactly FT cycles, held while saturated
    i_enchendo = 1'b1;
    run_check(FT - 1, 6'b100000, "fill_edge9");
    run_check(1, {1'b1, 1'b0, 1'b0, TO, TO, 1'b0}, "timeout_set");
    pulse_clear();
    run_check(0, {1'b1, 1'b0, 1'b0, TO, TO, 1'b0}, "timeout_clear_blocked");
    run_check(90, {1'b1, 1'b0, 1'b0, TO, TO, 1'b0}, "timeout_hold_100");
    i_enchendo = 1'b0;
    wait_cycles(1);
    pulse_clear();
    run_check(0, 6'b100000, "timeout_cleared");

    // Filling dropped one cycle short: no fault, timer restarts from zero
    i_enchendo = 1'b1;
    wait_cycles(FT - 1);
    i_enchendo = 1'b0;
    run_check(3, 6'b100000, "fill9_nofault");
    i_enchendo = 1'b1;
    run_check(FT - 1, 6'b100000, "fill9_restart");
    i_enchendo = 1'b0;
    wait_cycles(2);

    // Both fault kinds accumulate to 2'b11
    i_enchendo   = 1'b1;
    i_boia_vazia = 1'b1;
    run_check(FT, {1'b1, 1'b0, 1'b1, TO, TO, 1'b0}, "combo_timeout");
    i_boia_cheia = 1'b1;
    run_check(DEB + 2, {1'b1, 1'b1, 1'b1, TO, TO, 1'b0}, "combo_both_high");
    run_check(1, {1'b1, 1'b1, 1'b1, 1'b1, TO, 1'b1}, "combo_code11");

    // Asynchronous reset mid-fault, then re-qualification
    #2;
    reset = 1'b1;
    #1;
    run_check(0, 6'b000000, "reset_async");
    wait_cycles(2);
    reset = 1'b0;
    run_check(DEB + 1, 6'b000000, "requal_edge5");
    run_check(1, 6'b111000, "requal_edge6");
    run_check(1, 6'b111101, "requal_plaus");

    i_enchendo   = 1'b0;
    i_boia_cheia = 1'b0;
    i_boia_vazia = 1'b0;
    wait_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
